// File: rtl/demux32_1to4_buf_pkg.sv
// Shared constants and types for the buffered 32-bit 1-to-4 demultiplexer.
package demux32_1to4_buf_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned N_LANES = 4;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [1:0]        sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

    // Same shape as the datapath's 4-to-1 word selector, applied to lane counts.
    function automatic cnt_t sel_count(sel_t sel, cnt_t a, cnt_t b, cnt_t c, cnt_t d);
        cnt_t r;
        case (sel)
            SEL_A:   r = a;
            SEL_B:   r = b;
            SEL_C:   r = c;
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/demux32_1to4_buf_if.sv
// Upstream push port plus the four lane output handshakes of the demultiplexer.
interface demux32_1to4_buf_if;
    import demux32_1to4_buf_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    sel_t  in_sel;

    word_t outA, outB, outC, outD;
    logic  validA, validB, validC, validD;
    logic  readyA, readyB, readyC, readyD;
    cnt_t  countA, countB, countC, countD;

    modport slave (
        input  in_valid, in_data, in_sel,
        output in_ready,
        output outA, outB, outC, outD,
        output validA, validB, validC, validD,
        input  readyA, readyB, readyC, readyD,
        output countA, countB, countC, countD
    );

    modport master (
        output in_valid, in_data, in_sel,
        input  in_ready,
        input  outA, outB, outC, outD,
        input  validA, validB, validC, validD,
        output readyA, readyB, readyC, readyD,
        input  countA, countB, countC, countD
    );

endinterface

// File: rtl/demux32_1to4_buf_lane_fifo2.sv
// Two-entry lane FIFO with synchronous active-high reset; head is masked to 0 when empty.
module demux32_1to4_buf_lane_fifo2
    import demux32_1to4_buf_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  push_i,
    input  word_t data_i,
    input  logic  pop_i,
    output word_t head_o,
    output logic  valid_o,
    output cnt_t  count_o
);

    word_t mem_q [DEPTH];
    word_t mem_d [DEPTH];
    logic  wr_ptr_q, wr_ptr_d;
    logic  rd_ptr_q, rd_ptr_d;
    cnt_t  count_q, count_d;
    logic  do_push, do_pop;

    always_comb begin
        do_push  = push_i && (count_q != CNT_FULL);
        do_pop   = pop_i && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        valid_o = (count_q != '0);
        head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
        count_o = count_q;
    end

endmodule

// File: rtl/demux32_1to4_buf.sv
// Buffered 1-to-4 demultiplexer: routes each accepted word into one of four 2-entry lane FIFOs.
module demux32_1to4_buf
    import demux32_1to4_buf_pkg::*;
(
    input logic Clk,
    input logic Reset,
    demux32_1to4_buf_if.slave bus
);

    word_t              head [N_LANES];
    cnt_t               cnt  [N_LANES];
    logic [N_LANES-1:0] valid;
    logic [N_LANES-1:0] pop;
    logic [N_LANES-1:0] lane_push;
    logic               in_ready;

    // Acceptance depends only on the selected lane's occupancy, never on its ready.
    always_comb begin
        in_ready  = (sel_count(bus.in_sel, cnt[SEL_A], cnt[SEL_B], cnt[SEL_C], cnt[SEL_D])
                     != CNT_FULL);
        lane_push = '0;
        if (bus.in_valid && in_ready) begin
            lane_push[bus.in_sel] = 1'b1;
        end
        pop = {bus.readyD, bus.readyC, bus.readyB, bus.readyA};
    end

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        demux32_1to4_buf_lane_fifo2 u_fifo (
            .clk_i   (Clk),
            .rst_i   (Reset),
            .push_i  (lane_push[l]),
            .data_i  (bus.in_data),
            .pop_i   (pop[l]),
            .head_o  (head[l]),
            .valid_o (valid[l]),
            .count_o (cnt[l])
        );
    end

    always_comb begin
        bus.in_ready = in_ready;
        bus.outA     = head[SEL_A];
        bus.outB     = head[SEL_B];
        bus.outC     = head[SEL_C];
        bus.outD     = head[SEL_D];
        bus.validA   = valid[SEL_A];
        bus.validB   = valid[SEL_B];
        bus.validC   = valid[SEL_C];
        bus.validD   = valid[SEL_D];
        bus.countA   = cnt[SEL_A];
        bus.countB   = cnt[SEL_B];
        bus.countC   = cnt[SEL_C];
        bus.countD   = cnt[SEL_D];
    end

endmodule

// File: tb/tb_demux32_1to4_buf.sv
// Directed self-checking bench for demux32_1to4_buf.
module tb_demux32_1to4_buf;
    import demux32_1to4_buf_pkg::*;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    demux32_1to4_buf_if bus ();

    demux32_1to4_buf dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    word_t outs   [4];
    cnt_t  counts [4];
    logic  valids [4];

    assign outs[0]   = bus.outA;
    assign outs[1]   = bus.outB;
    assign outs[2]   = bus.outC;
    assign outs[3]   = bus.outD;
    assign counts[0] = bus.countA;
    assign counts[1] = bus.countB;
    assign counts[2] = bus.countC;
    assign counts[3] = bus.countD;
    assign valids[0] = bus.validA;
    assign valids[1] = bus.validB;
    assign valids[2] = bus.validC;
    assign valids[3] = bus.validD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_lane(input string tag, input int l, input int exp_cnt,
                              input logic [31:0] exp_head);
        check($sformatf("%s count%0d", tag, l), 32'(counts[l]), 32'(exp_cnt));
        check($sformatf("%s valid%0d", tag, l), 32'(valids[l]), 32'(exp_cnt != 0));
        check($sformatf("%s out%0d", tag, l), outs[l], exp_head);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic [3:0] r);
        bus.readyA = r[0];
        bus.readyB = r[1];
        bus.readyC = r[2];
        bus.readyD = r[3];
    endtask

    task automatic push(input logic [31:0] data, input logic [1:0] sel);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_sel   = sel;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h5555_5555;
        bus.in_sel   = SEL_A;
        set_ready(4'h0);

        // Reset held two cycles with a word offered
        tick();
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        for (int l = 0; l < 4; l++) check_lane("reset", l, 0, 32'h0);
        check("reset in_ready", 32'(bus.in_ready), 32'h1);

        // Routing to each lane
        push(32'h1111_1111, SEL_A);
        check_lane("route1", 0, 1, 32'h1111_1111);
        check_lane("route1", 1, 0, 32'h0);
        push(32'h2222_2222, SEL_B);
        push(32'h3333_3333, SEL_C);
        push(32'h4444_4444, SEL_D);
        check_lane("route", 0, 1, 32'h1111_1111);
        check_lane("route", 1, 1, 32'h2222_2222);
        check_lane("route", 2, 1, 32'h3333_3333);
        check_lane("route", 3, 1, 32'h4444_4444);
        set_ready(4'hF);
        tick();
        set_ready(4'h0);
        for (int l = 0; l < 4; l++) check_lane("drain", l, 0, 32'h0);

        // Full lane B with backpressure
        push(32'hA0, SEL_B);
        check_lane("fullB1", 1, 1, 32'hA0);
        push(32'hA1, SEL_B);
        check_lane("fullB2", 1, 2, 32'hA0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hA2;
        bus.in_sel   = SEL_B;
        bus.readyB   = 1'b1;
        #1;
        check("full in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        bus.readyB = 1'b0;
        #1;
        check("after pop in_ready", 32'(bus.in_ready), 32'h1);
        check_lane("popB", 1, 1, 32'hA1);
        tick();
        bus.in_valid = 1'b0;
        check_lane("refillB", 1, 2, 32'hA1);
        bus.readyB = 1'b1;
        tick();
        check_lane("orderB", 1, 1, 32'hA2);
        tick();
        check_lane("emptyB", 1, 0, 32'h0);
        tick();
        check_lane("underflowB", 1, 0, 32'h0);
        bus.readyB = 1'b0;

        // Simultaneous push/pop on lane C with pointer wrap
        push(32'hC0, SEL_C);
        check_lane("simC0", 2, 1, 32'hC0);
        bus.readyC = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hC1 + 32'(i);
            bus.in_sel   = SEL_C;
            tick();
            check($sformatf("simC count it%0d", i), 32'(counts[2]), 32'h1);
            check($sformatf("simC out it%0d", i), outs[2], 32'hC1 + 32'(i));
        end
        bus.in_valid = 1'b0;
        tick();
        bus.readyC = 1'b0;
        check_lane("simC end", 2, 0, 32'h0);

        // Parallel drain of all four lanes
        for (int l = 0; l < 4; l++) begin
            for (int k = 0; k < 2; k++) push(32'hF000_0000 | 32'(l * 16 + k), 2'(l));
        end
        for (int l = 0; l < 4; l++) check_lane("fill", l, 2, 32'hF000_0000 | 32'(l * 16));
        set_ready(4'hF);
        tick();
        for (int l = 0; l < 4; l++) check_lane("par1", l, 1, 32'hF000_0001 | 32'(l * 16));
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hF000_00AA;
        bus.in_sel   = SEL_A;
        #1;
        check("par in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        check_lane("par2", 0, 1, 32'hF000_00AA);
        for (int l = 1; l < 4; l++) check_lane("par2", l, 0, 32'h0);
        tick();
        set_ready(4'h0);
        check_lane("par3", 0, 0, 32'h0);

        // Reset mid-operation
        push(32'h1, SEL_A);
        push(32'h2, SEL_A);
        push(32'h3, SEL_B);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h4;
        bus.in_sel   = SEL_C;
        set_ready(4'b0011);
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        set_ready(4'h0);
        #1;
        for (int l = 0; l < 4; l++) check_lane("midrst", l, 0, 32'h0);
        check("midrst in_ready", 32'(bus.in_ready), 32'h1);
        push(32'hDEAD_BEEF, SEL_D);
        check_lane("postrst", 3, 1, 32'hDEAD_BEEF);
        check_lane("postrst", 2, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
